div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit.sv | 128 ++++++++++++
 tb/tb_div_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: 32-bit signed restoring divider for the MIPS-style HI/LO path.
// Quotient goes to lo and remainder to hi; the remainder takes the dividend's sign.
//
// Ports:
//   clk      - rising-edge clock
//   reset    - asynchronous, active-high reset
//   start    - division request (control_unit DivStart)
//   a, b     - signed dividend (rs) and signed divisor (rt)
//   hi, lo   - signed remainder and signed quotient; they hold until the next result
//   done     - one-cycle completion pulse (control_unit div_done_in)
//   div_zero - divide-by-zero flag, qualified by done
//   busy     - high whenever the unit is not idle
module div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        done,
    output logic        div_zero,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_t;

    state_t      state;
    logic [31:0] rem;
    logic [31:0] quo;
    logic [31:0] divisor;
    logic        sign_a;
    logic        sign_b;
    logic [5:0]  cnt;

    // Magnitudes as unsigned 32-bit values; |0x80000000| stays 0x80000000.
    logic [31:0] abs_a;
    logic [31:0] abs_b;

    assign abs_a = a[31] ? (~a + 32'd1) : a;
    assign abs_b = b[31] ? (~b + 32'd1) : b;

    // One restoring step. rem < divisor <= 2^31 always holds, so the
    // shifted remainder fits in 33 bits and the difference fits in 32.
    logic [32:0] rem_sh;
    logic        fits;
    logic [31:0] diff;
    logic [31:0] rem_nx;
    logic [31:0] quo_nx;

    assign rem_sh = {rem, quo[31]};
    assign fits   = rem_sh >= {1'b0, divisor};
    assign diff   = rem_sh[31:0] - divisor;
    assign rem_nx = fits ? diff : rem_sh[31:0];
    assign quo_nx = {quo[30:0], fits};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rem      <= '0;
            quo      <= '0;
            divisor  <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            busy     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done     <= 1'b0;
                    div_zero <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if (b == 32'd0) begin
                            // No iterations; hi/lo keep their old values.
                            state    <= DONE;
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                        end else begin
                            state   <= RUN;
                            quo     <= abs_a;
                            divisor <= abs_b;
                            sign_a  <= a[31];
                            sign_b  <= b[31];
                            rem     <= '0;
                            cnt     <= '0;
                        end
                    end
                end
                RUN: begin
                    rem <= rem_nx;
                    quo <= quo_nx;
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd31) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    lo    <= (sign_a ^ sign_b) ? (~quo + 32'd1) : quo;
                    hi    <= sign_a ? (~rem + 32'd1) : rem;
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE: begin
                    state    <= IDLE;
                    done     <= 1'b0;
                    div_zero <= 1'b0;
                    busy     <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        done;
    logic        div_zero;
    logic        busy;

    int n_checks;
    int n_fails;

    div_unit dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .b        (b),
        .hi       (hi),
        .lo       (lo),
        .done     (done),
        .div_zero (div_zero),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a one-cycle start; returns at the falling edge after the start edge.
    task automatic issue(input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        a     = av;
        b     = bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Runs a normal division and checks the full 34-cycle busy/done timing.
    task automatic run_div(input string name,
                           input logic [31:0] av, input logic [31:0] bv,
                           input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        int done_at;
        int busy_cnt;
        done_at  = 0;
        busy_cnt = 0;
        issue(av, bv);
        for (int k = 1; k <= 40; k++) begin
            if (busy) busy_cnt++;
            if (done && done_at == 0) begin
                done_at = k;
                n_checks++;
                if (lo !== exp_lo || hi !== exp_hi || div_zero !== 1'b0) begin
                    n_fails++;
                    $display("FAIL %s result: lo=%h hi=%h dz=%b, required lo=%h hi=%h dz=0",
                             name, lo, hi, div_zero, exp_lo, exp_hi);
                end
            end
            if (k < 40) @(negedge clk);
        end
        n_checks++;
        if (done_at != 34) begin
            n_fails++;
            $display("FAIL %s done_cycle: got %0d, required 34", name, done_at);
        end
        n_checks++;
        if (busy_cnt != 34) begin
            n_fails++;
            $display("FAIL %s busy_cycles: got %0d, required 34", name, busy_cnt);
        end
    endtask

    task automatic test_reset;
        start = 1'b0;
        a     = '0;
        b     = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({hi, lo, done, div_zero, busy} !== 67'd0) begin
            n_fails++;
            $display("FAIL reset_state: hi=%h lo=%h done=%b dz=%b busy=%b, required all 0",
                     hi, lo, done, div_zero, busy);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        run_div("basic_100_7", 32'd100, 32'd7, 32'd14, 32'd2);
        run_div("exact_9_3", 32'd9, 32'd3, 32'd3, 32'd0);
    endtask

    task automatic test_signed;
        run_div("neg_a", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_div("neg_b", 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
        run_div("neg_both", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF);
        run_div("small_a", 32'd3, 32'd10, 32'd0, 32'd3);
    endtask

    task automatic test_overflow;
        run_div("min_by_m1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        run_div("max_by_1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0);
    endtask

    task automatic test_div_zero;
        run_div("preload", 32'd100, 32'd7, 32'd14, 32'd2);
        issue(32'd5, 32'd0);
        n_checks++;
        if (done !== 1'b1 || div_zero !== 1'b1 || busy !== 1'b1) begin
            n_fails++;
            $display("FAIL dz_flags: done=%b dz=%b busy=%b, required 1 1 1",
                     done, div_zero, busy);
        end
        n_checks++;
        if (hi !== 32'd2 || lo !== 32'd14) begin
            n_fails++;
            $display("FAIL dz_hold: hi=%h lo=%h, required hi=2 lo=e", hi, lo);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || div_zero !== 1'b0 || busy !== 1'b0) begin
            n_fails++;
            $display("FAIL dz_end: done=%b dz=%b busy=%b, required 0 0 0",
                     done, div_zero, busy);
        end
    endtask

    task automatic test_reset_abort;
        int dones;
        dones = 0;
        issue(32'd100, 32'd7);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if ({hi, lo, done, div_zero, busy} !== 67'd0) begin
            n_fails++;
            $display("FAIL abort_reset: hi=%h lo=%h done=%b dz=%b busy=%b, required all 0",
                     hi, lo, done, div_zero, busy);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (done) dones++;
            @(negedge clk);
        end
        n_checks++;
        if (dones != 0) begin
            n_fails++;
            $display("FAIL abort_no_done: got %0d pulses, required 0", dones);
        end
        run_div("after_reset_9_3", 32'd9, 32'd3, 32'd3, 32'd0);
    endtask

    task automatic test_back_to_back;
        int dones;
        dones = 0;
        issue(32'd100, 32'd7);
        for (int k = 1; k <= 40; k++) begin
            if (done) dones++;
            if (k == 5 || k == 33) begin
                a     = 32'd9;
                b     = 32'd3;
                start = 1'b1;
            end else if (k == 6 || k == 34) begin
                start = 1'b0;
                a     = 32'd55;
                b     = 32'd0;
            end
            if (k == 34) begin
                n_checks++;
                if (done !== 1'b1 || lo !== 32'd14 || hi !== 32'd2) begin
                    n_fails++;
                    $display("FAIL b2b_result: done=%b lo=%h hi=%h, required 1 e 2",
                             done, lo, hi);
                end
            end
            @(negedge clk);
        end
        n_checks++;
        if (dones != 1) begin
            n_fails++;
            $display("FAIL b2b_pulses: got %0d, required 1", dones);
        end
        n_checks++;
        if (busy !== 1'b0 || lo !== 32'd14 || hi !== 32'd2) begin
            n_fails++;
            $display("FAIL b2b_idle: busy=%b lo=%h hi=%h, required 0 e 2", busy, lo, hi);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        test_reset;
        test_basic;
        test_signed;
        test_overflow;
        test_div_zero;
        test_reset_abort;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
